mult_div_unit: RTL

//  Parametrised multi-cycle multiply/divide unit holding HI/LO for the MIPS datapath.

---
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// MULT/MULTU/DIV/DIVU hold busy for a fixed latency and then commit to HI/LO
// with a one-cycle done pulse; MTHI/MTLO write directly when the unit is idle.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic                      div_by_zero;
    logic                      div_overflow;
    logic [WIDTH-1:0]          safe_b_s;
    logic [WIDTH-1:0]          safe_b_u;
    logic [2*WIDTH-1:0]        prod_u;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]          quot_u;
    logic [WIDTH-1:0]          rem_u;

    // Result arithmetic on the latched operands; divisors are forced to 1 for the
    // zero and most-negative/-1 cases so the dividers never see an undefined input
    // (the overflow case then yields quotient = most-negative, remainder = 0).
    always_comb begin
        div_by_zero  = (b_q == '0);
        div_overflow = (a_q == MOST_NEG) && (b_q == '1);
        safe_b_s     = (div_by_zero || div_overflow) ? ONE_W : b_q;
        safe_b_u     = div_by_zero ? ONE_W : b_q;
        prod_u       = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        prod_s       = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        quot_s       = $signed(a_q) / $signed(safe_b_s);
        rem_s        = $signed(a_q) % $signed(safe_b_s);
        quot_u       = a_q / safe_b_u;
        rem_u        = a_q % safe_b_u;
    end

    // Next-state logic: accept or move-to in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op <= 3'd3) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op[1:0];
                        cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = RUN;
                    end else if (op == 3'd4) begin
                        hi_d = A;
                    end else if (op == 3'd5) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    case (op_q)
                        2'd0: begin
                            hi_d = prod_s[2*WIDTH-1:WIDTH];
                            lo_d = prod_s[WIDTH-1:0];
                        end
                        2'd1: begin
                            hi_d = prod_u[2*WIDTH-1:WIDTH];
                            lo_d = prod_u[WIDTH-1:0];
                        end
                        2'd2: begin
                            if (!div_by_zero) begin
                                hi_d = rem_s;
                                lo_d = quot_s;
                            end
                        end
                        default: begin
                            if (!div_by_zero) begin
                                hi_d = rem_u;
                                lo_d = quot_u;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; asynchronous active-low reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
